// File: rtl/proc_core.sv
// proc_core: multicycle processor core with its own FETCH/EXEC/MEM/HALT
// sequencer, an 8 x DATA_W register file and a PC. Instruction and data
// memories are reached through req/ack handshakes, so any memory latency
// simply stretches the FETCH or MEM state.
//
// Optional feature: define PROC_MUL_EN to decode opcode 9 as MUL
// (rd = low DATA_W bits of rd*rs). Without it, opcode 9 is illegal.
module proc_core #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       iram_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dram_in,
  output logic [15:0]       ir_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_LDI   = 4'h4,
    OP_LOAD  = 4'h5,
    OP_STORE = 4'h6,
    OP_JZ    = 4'h7,
    OP_JMP   = 4'h8,
    OP_MUL   = 4'h9,
    OP_HALT  = 4'hF
  } op_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [8];

  // Instruction fields, always taken from the latched instruction register.
  op_t               op;
  logic [2:0]        rd_idx;
  logic [2:0]        rs_idx;
  logic [8:0]        imm9;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;

  assign op     = op_t'(ir_out[15:12]);
  assign rd_idx = ir_out[11:9];
  assign rs_idx = ir_out[8:6];
  assign imm9   = ir_out[8:0];
  assign rd_val = regs[rd_idx];
  assign rs_val = regs[rs_idx];

  // The fetch request is a pure function of state so it rises in the very
  // first cycle after reset; reset itself masks it.
  assign imem_req  = (state == S_FETCH) && !reset;
  assign imem_addr = pc;

  // Single-cycle EXEC results: register write value/enable, next PC, illegal.
  logic              exe_wr;
  logic [DATA_W-1:0] exe_val;
  logic [ADDR_W-1:0] exe_pc;
  logic              exe_ill;

  // Combinational decode of the instruction in EXEC.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    exe_wr  = 1'b0;
    exe_val = '0;
    exe_pc  = pc;
    exe_ill = 1'b0;
    case (op)
      OP_NOP:   ;
      OP_ADD:   begin exe_wr = 1'b1; exe_val = rd_val + rs_val; end
      OP_SUB:   begin exe_wr = 1'b1; exe_val = rd_val - rs_val; end
      OP_AND:   begin exe_wr = 1'b1; exe_val = rd_val & rs_val; end
      OP_LDI:   begin exe_wr = 1'b1; exe_val = DATA_W'(imm9);   end
      OP_LOAD, OP_STORE, OP_HALT: ;
      OP_JZ:    if (rd_val == '0) exe_pc = ADDR_W'(rs_val);
      // Offset is relative to the PC already incremented during FETCH.
      OP_JMP:   exe_pc = pc + ADDR_W'($signed(imm9));
`ifdef PROC_MUL_EN
      OP_MUL:   begin exe_wr = 1'b1; exe_val = rd_val * rs_val; end
`endif
      default:  exe_ill = 1'b1;
    endcase
  end

  // Sequencer, register file, PC and all registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: state updates use non-blocking assignments so every register in
    // this block samples the values from before the edge.
    if (reset) begin
      state      <= S_FETCH;
      pc         <= ADDR_W'(RESET_PC);
      // NOTE: the register file is architecturally zero after reset, so it
      // is reset along with the rest of the state rather than left as RAM.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      ir_out     <= '0;
      bus_out    <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir_out <= iram_in;
            pc     <= pc + ADDR_W'(1);
            state  <= S_EXEC;
          end
        end

        S_EXEC: begin
          state <= S_FETCH;
          case (op)
            OP_LOAD, OP_STORE: begin
              // Address and data are captured here, so a LOAD with rd == rs
              // still uses the original address.
              dmem_req   <= 1'b1;
              dmem_we    <= (op == OP_STORE);
              dmem_addr  <= ADDR_W'(rs_val);
              dmem_wdata <= rd_val;
              state      <= S_MEM;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              if (exe_wr) begin
                regs[rd_idx] <= exe_val;
                bus_out      <= exe_val;
              end
              pc <= exe_pc;
              if (exe_ill) illegal <= 1'b1;
            end
          endcase
        end

        S_MEM: begin
          if (dmem_ack) begin
            if (!dmem_we) begin
              regs[rd_idx] <= dram_in;
              bus_out      <= dram_in;
            end
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= S_FETCH;
          end
        end

        S_HALT: halted <= 1'b1;

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
